// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce FSM states, frame results,
// and a constant-foldable clog2 used to size counters and codes.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_PRESSED,
        S_REL_DB
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_frame_acc.sv
// Row strobe generator and per-frame column accumulator. The frame result is
// presented combinationally on the frame-end sample cycle so the FSM can act on that edge.
module keypad_frame_acc
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int CODE_W   = clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_n,
    output logic [ROWS-1:0]   row_n,
    output logic              frame_done,
    output frame_t            frame_result,
    output logic [CODE_W-1:0] frame_code
);

    localparam int DIV_W = clog2(SCAN_DIV);
    localparam int ROW_W = clog2(ROWS);

    logic [DIV_W-1:0]  div_cnt;
    logic [ROW_W-1:0]  row_idx;
    logic [ROW_W-1:0]  next_row;
    logic              acc_valid;
    logic              acc_multi;
    logic [CODE_W-1:0] acc_code;
    logic              sample;
    logic              last_row;
    int                zeros;
    int                zero_col;
    logic [CODE_W-1:0] hit_code;
    logic              next_valid;
    logic              next_multi;

    assign sample   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign last_row = (row_idx == ROW_W'(ROWS - 1));
    assign next_row = last_row ? '0 : row_idx + 1'b1;

    always_comb begin
        zeros    = 0;
        zero_col = 0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_n[c]) begin
                zeros    = zeros + 1;
                zero_col = c;
            end
        end
        hit_code = CODE_W'(int'(row_idx) * COLS + zero_col);
        // A lone hit on a frame that already holds a code makes it a chord.
        next_multi   = acc_multi || (zeros > 1) || (zeros == 1 && acc_valid);
        next_valid   = acc_valid || (zeros == 1);
        frame_done   = sample && last_row;
        frame_code   = acc_valid ? acc_code : hit_code;
        frame_result = next_multi ? FR_MULTI : (next_valid ? FR_SINGLE : FR_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            row_idx   <= '0;
            row_n     <= ~ROWS'(1);
            acc_valid <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
        end else if (sample) begin
            div_cnt <= '0;
            row_idx <= next_row;
            row_n   <= ~(ROWS'(1) << next_row);
            if (last_row) begin
                acc_valid <= 1'b0;
                acc_multi <= 1'b0;
                acc_code  <= '0;
            end else begin
                acc_valid <= next_valid;
                acc_multi <= next_multi;
                if (!acc_valid && zeros == 1) acc_code <= hit_code;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Keypad scanner top: frame-level debounce FSM producing key code, press and
// release pulses, and a held level. Chords never start a press.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 3,
    parameter int CODE_W   = clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_n,
    output logic [ROWS-1:0]   row_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held
);

    localparam int CNT_W = clog2(DEBOUNCE + 1);

    logic              frame_done;
    frame_t            frame_result;
    logic [CODE_W-1:0] frame_code;
    state_t            state;
    logic [CODE_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    logic              at_limit;

    keypad_frame_acc #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .CODE_W   (CODE_W)
    ) u_frame_acc (
        .clk          (clk),
        .rst          (rst),
        .col_n        (col_n),
        .row_n        (row_n),
        .frame_done   (frame_done),
        .frame_result (frame_result),
        .frame_code   (frame_code)
    );

    // True when this frame's qualifying result completes the debounce run.
    assign at_limit = (int'(cnt) + 1) >= DEBOUNCE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cand        <= '0;
            cnt         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (frame_done) begin
                case (state)
                    S_IDLE: begin
                        if (frame_result == FR_SINGLE) begin
                            cand <= frame_code;
                            cnt  <= CNT_W'(1);
                            if (DEBOUNCE <= 1) begin
                                state     <= S_PRESSED;
                                key_code  <= frame_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= S_PRESS_DB;
                            end
                        end
                    end
                    S_PRESS_DB: begin
                        if (frame_result == FR_SINGLE && frame_code == cand) begin
                            if (at_limit) begin
                                state     <= S_PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (frame_result == FR_SINGLE) begin
                            cand <= frame_code;
                            cnt  <= CNT_W'(1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (frame_result == FR_NONE) begin
                            cnt <= CNT_W'(1);
                            if (DEBOUNCE <= 1) begin
                                state       <= S_IDLE;
                                key_release <= 1'b1;
                                key_held    <= 1'b0;
                            end else begin
                                state <= S_REL_DB;
                            end
                        end
                    end
                    S_REL_DB: begin
                        if (frame_result == FR_NONE) begin
                            if (at_limit) begin
                                state       <= S_IDLE;
                                key_release <= 1'b1;
                                key_held    <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= S_PRESSED;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a key-matrix model drives col_n from row_n,
// and a run-length reference decides per frame when press/release are accepted.
module tb_keypad_scan_debounce;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = ROWS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_held;
    logic [15:0] keys = '0;

    int errors = 0;
    int checks = 0;

    // Reference state: press run length, quiet run length, held flag, codes.
    int m_held  = 0;
    int m_run   = 0;
    int m_quiet = 0;
    int m_cand  = 0;
    int m_code  = 0;

    keypad_scan_debounce #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col_n       (col_n),
        .row_n       (row_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row_n[r] && keys[r*COLS+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held  = 0;
        m_run   = 0;
        m_quiet = 0;
        m_cand  = 0;
        m_code  = 0;
    endtask

    // Runs one full frame with the current key set, then compares the outputs
    // seen just after the frame-end edge against the reference decision.
    task automatic frame(input string tag);
        int stray;
        int n;
        int code;
        int exp_valid;
        int exp_rel;
        stray = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            if (i < FRAME - 1 && (key_valid !== 1'b0 || key_release !== 1'b0)) stray++;
        end
        n    = 0;
        code = 0;
        for (int k = 0; k < ROWS * COLS; k++) begin
            if (keys[k]) begin
                n++;
                code = k;
            end
        end
        exp_valid = 0;
        exp_rel   = 0;
        if (m_held == 0) begin
            if (n == 1) begin
                if (m_run > 0 && code == m_cand) m_run++;
                else begin
                    m_cand = code;
                    m_run  = 1;
                end
                if (m_run >= DEB) begin
                    m_held    = 1;
                    m_code    = code;
                    exp_valid = 1;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_quiet++;
                if (m_quiet >= DEB) begin
                    m_held  = 0;
                    exp_rel = 1;
                    m_quiet = 0;
                end
            end else begin
                m_quiet = 0;
            end
        end
        check({tag, ".midframe_pulse"}, stray, 0);
        check({tag, ".key_valid"}, key_valid, exp_valid);
        check({tag, ".key_release"}, key_release, exp_rel);
        check({tag, ".key_held"}, key_held, m_held);
        check({tag, ".key_code"}, key_code, m_code);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check({tag, ".row_n"}, row_n, 4'b1110);
        check({tag, ".key_code"}, key_code, 0);
        check({tag, ".key_valid"}, key_valid, 0);
        check({tag, ".key_release"}, key_release, 0);
        check({tag, ".key_held"}, key_held, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] er;
        int         r;
        keys = '0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Row strobe walk over the first frame after reset release.
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk);
            #1;
            er = ~(4'b0001 << ((i / SCAN_DIV) % ROWS));
            check($sformatf("row_step%0d", i), row_n, er);
        end

        // Press and hold key (2,1).
        keys[9] = 1'b1;
        for (int f = 0; f < 5; f++) frame($sformatf("press9_f%0d", f + 1));
        check("press9.code_final", key_code, 9);

        // Release it.
        keys = '0;
        for (int f = 0; f < 4; f++) frame($sformatf("rel9_f%0d", f + 1));
        check("rel9.code_kept", key_code, 9);
        check("rel9.held_low", key_held, 0);

        // Bounce on key (0,3): 2 closed, 1 open, 3 closed.
        keys[3] = 1'b1;
        for (int f = 0; f < 2; f++) frame($sformatf("bounce_a%0d", f + 1));
        keys = '0;
        frame("bounce_gap");
        keys[3] = 1'b1;
        for (int f = 0; f < 3; f++) frame($sformatf("bounce_b%0d", f + 1));
        check("bounce.code", key_code, 3);
        keys = '0;
        for (int f = 0; f < 4; f++) frame($sformatf("bounce_rel%0d", f + 1));

        // Chord from idle never accepted.
        keys[4]  = 1'b1;
        keys[14] = 1'b1;
        for (int f = 0; f < 6; f++) frame($sformatf("chord_idle%0d", f + 1));
        check("chord_idle.held", key_held, 0);
        keys = '0;
        frame("chord_gap");

        // Hold (1,0), then add (3,2) while held.
        keys[4] = 1'b1;
        for (int f = 0; f < 4; f++) frame($sformatf("hold4_f%0d", f + 1));
        keys[14] = 1'b1;
        for (int f = 0; f < 3; f++) frame($sformatf("chord_held%0d", f + 1));
        keys[14] = 1'b0;
        for (int f = 0; f < 2; f++) frame($sformatf("chord_off%0d", f + 1));
        check("chord_held.code", key_code, 4);
        check("chord_held.held", key_held, 1);

        // Reset mid-frame while held; key stays closed.
        repeat (7) @(posedge clk);
        #1;
        do_reset("midreset");
        for (int f = 0; f < 3; f++) frame($sformatf("post_reset%0d", f + 1));
        check("post_reset.code", key_code, 4);
        keys = '0;
        for (int f = 0; f < 4; f++) frame($sformatf("post_reset_rel%0d", f + 1));

        // Randomised key activity with sticky choices so presses complete.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) >= 7) begin
                r    = int'($urandom_range(0, 5));
                keys = '0;
                if (r >= 2 && r <= 4) begin
                    keys[$urandom_range(0, 15)] = 1'b1;
                end else if (r == 5) begin
                    keys[$urandom_range(0, 7)]  = 1'b1;
                    keys[$urandom_range(8, 15)] = 1'b1;
                end
            end
            frame($sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
